pu_ld_obuf_seq: RTL and testbench

Next-generation OBUF load sequencer for the PU. It holds its own NUM_LOOPS-deep nested loop counters and strides, so it needs no external loop controller. It splits each word address into BEATS sub-beat requests and limits in-flight reads with a credit counter. It sits between the PU instruction decoder (config/start) and the OBUF read port feeding the LD stream FIFO.

---
 rtl/pu_ld_obuf_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_pu_ld_obuf_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_ld_obuf_seq.sv
// pu_ld_obuf_seq: OBUF load sequencer for the PU LD stream.
// Walks up to NUM_LOOPS nested loops from a base word address, splits each
// word into BEATS sub-beat reads and limits unreturned reads with credits.
// Optional stall counter is built when PU_LD_OBUF_SEQ_PERF_EN is defined.
module pu_ld_obuf_seq #(
    parameter int unsigned NUM_LOOPS       = 4,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned ADDR_STRIDE_W   = ADDR_WIDTH,
    parameter int unsigned LOOP_ITER_W     = 16,
    parameter int unsigned BEATS           = 2,
    parameter int unsigned BEAT_W          = (BEATS > 1) ? $clog2(BEATS) : 0,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CREDIT_W        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         done,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic                         cfg_loop_stride_v,
    input  logic [ADDR_STRIDE_W-1:0]     cfg_loop_stride,
    input  logic [2:0]                   cfg_loop_stride_type,
    input  logic                         cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0]       cfg_loop_iter,
    input  logic [2:0]                   cfg_loop_iter_type,
    output logic                         mem_req,
    input  logic                         mem_ready,
    output logic [ADDR_WIDTH+BEAT_W-1:0] mem_addr,
    input  logic                         mem_rsp_v,
    input  logic                         obuf_ld_stream_write_ready,
    output logic                         busy,
    output logic [31:0]                  perf_stall_cycles
);

    localparam int unsigned SLOT_W  = $clog2(NUM_LOOPS + 1);
    localparam int unsigned IDX_W   = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
    localparam int unsigned BEAT_SW = (BEAT_W > 0) ? BEAT_W : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q;
    state_t                   state_d;

    logic [LOOP_ITER_W-1:0]   iter_q     [NUM_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_q   [NUM_LOOPS];
    logic [SLOT_W-1:0]        iter_cnt_q;
    logic [SLOT_W-1:0]        stride_cnt_q;
    logic [LOOP_ITER_W-1:0]   idx_q      [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0]   idx_d      [NUM_LOOPS];
    logic [ADDR_WIDTH-1:0]    stride_ext [NUM_LOOPS];
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [ADDR_WIDTH-1:0]    addr_d;
    logic [BEAT_SW-1:0]       beat_q;
    logic [CREDIT_W-1:0]      credit_q;

    logic xfer_c;
    logic beat_wrap_c;
    logic last_c;
    logic start_acc_c;
    logic rsp_acc_c;
    logic iter_wr_c;
    logic stride_wr_c;

    assign xfer_c      = mem_req && mem_ready;
    assign start_acc_c = (state_q == S_IDLE) && start;
    assign rsp_acc_c   = mem_rsp_v && (credit_q != '0);
    assign beat_wrap_c = (BEATS == 1) || (beat_q == BEAT_SW'(BEATS - 1));
    assign iter_wr_c   = (state_q == S_IDLE) && cfg_loop_iter_v &&
                         (cfg_loop_iter_type == 3'd0) &&
                         (iter_cnt_q < SLOT_W'(NUM_LOOPS));
    assign stride_wr_c = (state_q == S_IDLE) && cfg_loop_stride_v &&
                         (cfg_loop_stride_type == 3'd0) &&
                         (stride_cnt_q < SLOT_W'(NUM_LOOPS));

    // Beat suffix only exists when a word spans several beats
    generate
        if (BEATS > 1) begin : g_beat
            assign mem_addr = {addr_q, beat_q};
        end else begin : g_nobeat
            assign mem_addr = addr_q;
        end
    endgenerate

    // Sign-extended stride per slot; unwritten slots step by zero
    always_comb begin
        for (int i = 0; i < NUM_LOOPS; i++) begin
            stride_ext[i] = '0;
            if (SLOT_W'(i) < stride_cnt_q) begin
                stride_ext[i] = ADDR_WIDTH'($signed(stride_q[i]));
            end
        end
    end

    // Odometer step: innermost active slot counts first, wrapped slots rewind the address
    always_comb begin
        idx_d  = idx_q;
        addr_d = addr_q;
        last_c = 1'b1;
        for (int i = NUM_LOOPS - 1; i >= 0; i--) begin
            if (last_c && (SLOT_W'(i) < iter_cnt_q)) begin
                if (idx_q[i] == iter_q[i]) begin
                    idx_d[i] = '0;
                    addr_d   = addr_d - ADDR_WIDTH'(ADDR_WIDTH'(iter_q[i]) * stride_ext[i]);
                end else begin
                    idx_d[i] = idx_q[i] + LOOP_ITER_W'(1);
                    addr_d   = addr_d + stride_ext[i];
                    last_c   = 1'b0;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs; mem_req never looks at mem_ready
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (iter_cnt_q == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                busy    = 1'b1;
                mem_req = obuf_ld_stream_write_ready &&
                          (credit_q < CREDIT_W'(MAX_OUTSTANDING));
                if (mem_req && mem_ready && beat_wrap_c && last_c) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((credit_q == '0) || ((credit_q == CREDIT_W'(1)) && mem_rsp_v)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Loop configuration slots, filled in order and cleared at the end of a sequence
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_cnt_q   <= '0;
            stride_cnt_q <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                iter_q[i]   <= '0;
                stride_q[i] <= '0;
            end
        end else if (state_q == S_DONE) begin
            iter_cnt_q   <= '0;
            stride_cnt_q <= '0;
        end else begin
            if (iter_wr_c) begin
                iter_q[iter_cnt_q[IDX_W-1:0]] <= cfg_loop_iter;
                iter_cnt_q                    <= iter_cnt_q + SLOT_W'(1);
            end
            if (stride_wr_c) begin
                stride_q[stride_cnt_q[IDX_W-1:0]] <= cfg_loop_stride;
                stride_cnt_q                      <= stride_cnt_q + SLOT_W'(1);
            end
        end
    end

    // Word address, loop indices and beat position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            beat_q <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                idx_q[i] <= '0;
            end
        end else if (start_acc_c) begin
            addr_q <= base_addr;
            beat_q <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                idx_q[i] <= '0;
            end
        end else if (xfer_c) begin
            if (beat_wrap_c) begin
                beat_q <= '0;
                addr_q <= addr_d;
                idx_q  <= idx_d;
            end else begin
                beat_q <= beat_q + BEAT_SW'(1);
            end
        end
    end

    // Outstanding-read credits; a response with nothing outstanding is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q <= '0;
        end else begin
            case ({xfer_c, rsp_acc_c})
                2'b10:   credit_q <= credit_q + CREDIT_W'(1);
                2'b01:   credit_q <= credit_q - CREDIT_W'(1);
                default: credit_q <= credit_q;
            endcase
        end
    end

`ifdef PU_LD_OBUF_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of BUSY cycles without a transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (start_acc_c) begin
            perf_q <= '0;
        end else if ((state_q == S_BUSY) && !xfer_c && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pu_ld_obuf_seq.sv
// tb_pu_ld_obuf_seq: scoreboard bench for the OBUF load sequencer.
// Expected addresses come from a flat-index loop model; a negedge monitor
// pops them on every accepted request and tracks outstanding reads.
`timescale 1ns/1ps
module tb_pu_ld_obuf_seq;

    localparam int unsigned NL   = 4;
    localparam int unsigned MAXO = 4;
    localparam int unsigned NB   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [7:0]  base_addr;
    logic        cfg_loop_stride_v;
    logic [7:0]  cfg_loop_stride;
    logic [2:0]  cfg_loop_stride_type;
    logic        cfg_loop_iter_v;
    logic [15:0] cfg_loop_iter;
    logic [2:0]  cfg_loop_iter_type;
    logic        mem_req;
    logic        mem_ready;
    logic [8:0]  mem_addr;
    logic        mem_rsp_v;
    logic        wr_ready;
    logic        busy;
    logic [31:0] perf_stall_cycles;

    pu_ld_obuf_seq dut (
        .clk                        (clk),
        .reset                      (reset),
        .start                      (start),
        .done                       (done),
        .base_addr                  (base_addr),
        .cfg_loop_stride_v          (cfg_loop_stride_v),
        .cfg_loop_stride            (cfg_loop_stride),
        .cfg_loop_stride_type       (cfg_loop_stride_type),
        .cfg_loop_iter_v            (cfg_loop_iter_v),
        .cfg_loop_iter              (cfg_loop_iter),
        .cfg_loop_iter_type         (cfg_loop_iter_type),
        .mem_req                    (mem_req),
        .mem_ready                  (mem_ready),
        .mem_addr                   (mem_addr),
        .mem_rsp_v                  (mem_rsp_v),
        .obuf_ld_stream_write_ready (wr_ready),
        .busy                       (busy),
        .perf_stall_cycles          (perf_stall_cycles)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q [$];
    int m_iter [$];
    int m_stride [$];
    int outst     = 0;
    int xfer_cnt  = 0;
    int done_seen = 0;
    int stall_cnt = 0;

    int rdy_pct  = 100;
    int srdy_pct = 100;
    int rsp_pct  = 50;
    bit rsp_kick = 1'b0;
    bit stray_en = 1'b1;

    logic       prev_stall = 1'b0;
    logic [8:0] prev_addr  = '0;
    logic       mon_xfer;
    logic       mon_busy_phase;
    logic [8:0] mon_exp;
    longint     mon_perf_exp;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory/stream side driver, applied after the main process each cycle
    initial begin
        mem_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_rsp_v = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_ready = (int'($urandom_range(99)) < rdy_pct);
            wr_ready  = (int'($urandom_range(99)) < srdy_pct);
            mem_rsp_v = rsp_kick ||
                        ((outst > 0) && (int'($urandom_range(99)) < rsp_pct)) ||
                        ((outst == 0) && stray_en && ($urandom_range(99) < 5));
        end
    end

    // Monitor: request gating, address scoreboard, credit model, done checks
    always @(negedge clk) begin
        if (reset) begin
            mon_busy_phase = busy && (exp_q.size() > 0);
            chk("mem_req", longint'(mem_req),
                longint'(mon_busy_phase && wr_ready && (outst < MAXO)));
            mon_xfer = mem_req && mem_ready;
            if (prev_stall && mem_req) chk("addr_hold", longint'(mem_addr), longint'(prev_addr));
            prev_stall = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            if (mon_busy_phase && !mon_xfer) stall_cnt++;
            if (mon_xfer) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_req", longint'(mem_addr), -1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("mem_addr", longint'(mem_addr), longint'(mon_exp));
                end
            end
            if (done) begin
                done_seen++;
                chk("done_pending", exp_q.size(), 0);
                chk("done_credits", outst, 0);
`ifdef PU_LD_OBUF_SEQ_PERF_EN
                mon_perf_exp = longint'(stall_cnt);
`else
                mon_perf_exp = 0;
`endif
                chk("perf_at_done", longint'(perf_stall_cycles), mon_perf_exp);
            end
            outst = outst + (mon_xfer ? 1 : 0) - ((mem_rsp_v && outst > 0) ? 1 : 0);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cfg_iter(input int val, input int typ);
        cfg_loop_iter_v    = 1'b1;
        cfg_loop_iter      = 16'(val);
        cfg_loop_iter_type = 3'(typ);
        if (typ == 0 && m_iter.size() < NL) m_iter.push_back(val);
        @(posedge clk); #1;
        cfg_loop_iter_v = 1'b0;
    endtask

    task automatic cfg_stride(input int val, input int typ);
        cfg_loop_stride_v    = 1'b1;
        cfg_loop_stride      = 8'(val);
        cfg_loop_stride_type = 3'(typ);
        if (typ == 0 && m_stride.size() < NL) m_stride.push_back(val);
        @(posedge clk); #1;
        cfg_loop_stride_v = 1'b0;
    endtask

    // Expected word sequence: flat index decomposed into loop digits, innermost fastest
    task automatic start_seq(input logic [7:0] b);
        int l;
        int total;
        int rem;
        int w;
        int t;
        base_addr = b;
        start     = 1'b1;
        stall_cnt = 0;
        l = m_iter.size();
        if (l > 0) begin
            total = 1;
            for (int i = 0; i < l; i++) total = total * (m_iter[i] + 1);
            for (int n = 0; n < total; n++) begin
                rem = n;
                w   = int'(b);
                for (int i = l - 1; i >= 0; i--) begin
                    t   = m_iter[i] + 1;
                    w   = w + (rem % t) * ((i < m_stride.size()) ? m_stride[i] : 0);
                    rem = rem / t;
                end
                for (int bt = 0; bt < NB; bt++) exp_q.push_back({8'(w), 1'(bt)});
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done; optionally poke ignored start/config writes while busy
    task automatic wait_done(input int d0, input int bound, input bit glitch);
        int cyc;
        cyc = 0;
        while (done_seen == d0 && cyc < bound) begin
            @(posedge clk); #1;
            start           = 1'b0;
            cfg_loop_iter_v = 1'b0;
            cyc++;
            if (glitch && busy && $urandom_range(15) == 0) begin
                if ($urandom_range(1) == 0) begin
                    start     = 1'b1;
                    base_addr = 8'($urandom);
                end else begin
                    cfg_loop_iter_v    = 1'b1;
                    cfg_loop_iter      = 16'd1;
                    cfg_loop_iter_type = 3'd0;
                end
            end
        end
        start           = 1'b0;
        cfg_loop_iter_v = 1'b0;
        chk("done_seen", done_seen - d0, 1);
    endtask

    task automatic seq_end(input int d0);
        @(posedge clk); #1;
        chk("done_once", done_seen - d0, 1);
        chk("idle_busy", longint'(busy), 0);
        m_iter.delete();
        m_stride.delete();
    endtask

    initial begin
        int d0;
        int x0;
        int ni;
        int ns;
        logic [8:0] a0;

        reset                = 1'b0;
        start                = 1'b0;
        base_addr            = '0;
        cfg_loop_stride_v    = 1'b0;
        cfg_loop_stride      = '0;
        cfg_loop_stride_type = '0;
        cfg_loop_iter_v      = 1'b0;
        cfg_loop_iter        = '0;
        cfg_loop_iter_type   = '0;
        #3;
        chk("rst_mem_req", longint'(mem_req), 0);
        chk("rst_mem_addr", longint'(mem_addr), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_perf", longint'(perf_stall_cycles), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Two-loop walk: iters {1,2}, strides {16,1}, base 0x10, full throughput
        rdy_pct = 100; srdy_pct = 100; rsp_pct = 50;
        cfg_iter(1, 0); cfg_iter(2, 0);
        cfg_stride(16, 0); cfg_stride(1, 0);
        d0 = done_seen;
        start_seq(8'h10);
        @(negedge clk);
        chk("lat_req", longint'(mem_req), 1);
        chk("lat_addr", longint'(mem_addr), longint'(9'h020));
        wait_done(d0, 500, 1'b0);
        seq_end(d0);

        // Zero loops: done the cycle after start, no requests
        d0 = done_seen;
        start_seq(8'h33);
        @(negedge clk);
        chk("zero_done", longint'(done), 1);
        wait_done(d0, 50, 1'b0);
        seq_end(d0);

        // Credit limit: no responses caps transfers, one response frees one slot
        stray_en = 1'b0; rsp_pct = 0;
        cfg_iter(7, 0); cfg_stride(3, 0);
        d0 = done_seen;
        x0 = xfer_cnt;
        start_seq(8'h40);
        repeat (15) @(posedge clk);
        #1;
        chk("credit_cap", xfer_cnt - x0, MAXO);
        rsp_kick = 1'b1;
        @(posedge clk); #1;
        rsp_kick = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("credit_one_more", xfer_cnt - x0, MAXO + 1);
        rsp_pct = 60; stray_en = 1'b1;
        wait_done(d0, 500, 1'b0);
        seq_end(d0);

        // Backpressure: mem_ready low for 5 cycles holds the request
        cfg_iter(5, 0); cfg_stride(2, 0);
        d0 = done_seen;
        start_seq(8'h80);
        repeat (3) @(posedge clk);
        #1 rdy_pct = 0;
        @(negedge clk);
        a0 = mem_addr;
        x0 = xfer_cnt;
        repeat (5) @(negedge clk);
        chk("bp_no_xfer", xfer_cnt - x0, 0);
        chk("bp_addr", longint'(mem_addr), longint'(a0));
        @(posedge clk); #1 rdy_pct = 100;
        wait_done(d0, 500, 1'b0);
        seq_end(d0);

        // Address wrap: base 0xFE, stride 1, iter 3
        cfg_iter(3, 0); cfg_stride(1, 0);
        d0 = done_seen;
        start_seq(8'hFE);
        wait_done(d0, 500, 1'b0);
        seq_end(d0);

        // Randomized configurations, throughput and ignored writes
        for (int s = 0; s < 25; s++) begin
            rdy_pct  = int'($urandom_range(100, 50));
            srdy_pct = int'($urandom_range(100, 50));
            rsp_pct  = int'($urandom_range(90, 30));
            ni = int'($urandom_range(5));
            ns = int'($urandom_range(5));
            for (int i = 0; i < 5; i++) begin
                if (i < ni) cfg_iter(int'($urandom_range(2)),
                                     ($urandom_range(7) == 0) ? int'($urandom_range(7, 1)) : 0);
                if (i < ns) cfg_stride(int'($urandom_range(255)),
                                       ($urandom_range(7) == 0) ? int'($urandom_range(7, 1)) : 0);
            end
            d0 = done_seen;
            start_seq(8'($urandom));
            wait_done(d0, 3000, 1'b1);
            seq_end(d0);
        end

        // Reset mid-run: everything returns to zero and no done follows
        rdy_pct = 100; srdy_pct = 100; rsp_pct = 50;
        cfg_iter(9, 0); cfg_stride(5, 0);
        d0 = done_seen;
        start_seq(8'h21);
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_req", longint'(mem_req), 0);
        chk("mid_rst_addr", longint'(mem_addr), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_done", longint'(done), 0);
        chk("mid_rst_perf", longint'(perf_stall_cycles), 0);
        exp_q.delete();
        m_iter.delete();
        m_stride.delete();
        outst = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_seen - d0, 0);
        chk("post_rst_busy", longint'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #900000;
        fails++;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
